// File: rtl/wrr_grant_capture_buf_if.sv
// ---------------------------------------------------------------------------
// wrr_grant_capture_buf_if
//   Bundles the signals between the WRR arbiter / requesters / consumer and
//   the grant capture buffer.
//
//   Handshake rule for the consumer side (valid/ready):
//     out_valid is asserted by the buffer whenever an entry is held. While
//     out_valid=1 and out_ready=0, out_data and out_src are held stable. A
//     transfer (pop) happens on a rising clk edge where out_valid=1 and
//     out_ready=1. out_valid does not depend combinationally on out_ready.
//
//   Signals
//     gnt        one-hot (or zero) grant from the arbiter
//     src_data   per-requester payloads, requester i at [i*DW +: DW]
//     out_valid  FIFO head valid
//     out_ready  consumer accepts head
//     out_data   head payload
//     out_src    head requester index
//     count      current FIFO occupancy
//     stall      requesters must deassert req
//     err_ovf    sticky: grant dropped because FIFO full
//     err_multi  sticky: multi-hot grant seen
//     err_clr    clears both sticky errors
//
//   Modports
//     slave   : the capture buffer
//     master  : the environment (arbiter, requesters, consumer)
// ---------------------------------------------------------------------------
interface wrr_grant_capture_buf_if #(
  parameter int N  = 16,
  parameter int DW = 32,
  parameter int IW = 4,
  parameter int CW = 3
);
  logic [N-1:0]    gnt;
  logic [N*DW-1:0] src_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_src;
  logic [CW-1:0]   count;
  logic            stall;
  logic            err_ovf;
  logic            err_multi;
  logic            err_clr;

  modport slave (
    input  gnt, src_data, out_ready, err_clr,
    output out_valid, out_data, out_src, count, stall, err_ovf, err_multi
  );

  modport master (
    output gnt, src_data, out_ready, err_clr,
    input  out_valid, out_data, out_src, count, stall, err_ovf, err_multi
  );
endinterface

// File: rtl/wrr_grant_capture_buf.sv
// ---------------------------------------------------------------------------
// wrr_grant_capture_buf
//   Downstream stage of the 16-way weighted round-robin arbiter. Captures the
//   payload and index of the granted requester into a small FIFO, presents
//   the FIFO head on a valid/ready interface, drives a stall back to the
//   requesters, and keeps sticky protocol error flags.
//
//   Ports
//     clk    in   clock, all logic on rising edge
//     rst_n  in   synchronous active-low reset
//     bus    slave modport of wrr_grant_capture_buf_if (gnt, src_data,
//            out_valid/out_ready/out_data/out_src, count, stall,
//            err_ovf, err_multi, err_clr)
//
//   Valid/ready: see wrr_grant_capture_buf_if. There is no bypass path; an
//   entry captured at edge t is visible after edge t.
// ---------------------------------------------------------------------------
module wrr_grant_capture_buf #(
  parameter int N     = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(N),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic                      clk,
  input logic                      rst_n,
  wrr_grant_capture_buf_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 2);

  // Storage
  logic [DW-1:0] mem_data [DEPTH];
  logic [IW-1:0] mem_src  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          stall_q;
  logic          err_ovf_q;
  logic          err_multi_q;

  // Datapath / control
  logic          push;
  logic          pop;
  logic          accept;
  logic          ovf_evt;
  logic          multi_evt;
  logic [IW-1:0] grant_idx;
  logic [DW-1:0] grant_data;
  logic [CW-1:0] count_next;
  logic          head_valid;

  // Lowest set bit wins; scanning from the top lets lower bits overwrite.
  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.gnt[i]) grant_idx = IW'(i);
    end
  end

  assign grant_data = bus.src_data[grant_idx*DW +: DW];

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_evt  = (bus.gnt & (bus.gnt - N'(1))) != '0;

  assign head_valid = (count_q != '0);
  assign push       = |bus.gnt;
  assign pop        = head_valid & bus.out_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign accept     = push & ((count_q < FULL_CNT) | pop);
  assign ovf_evt    = push & ~accept;

  always_comb begin
    count_next = count_q;
    if (accept && !pop)      count_next = count_q + CW'(1);
    else if (pop && !accept) count_next = count_q - CW'(1);
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_next;
      // Two entries of slack cover the arbiter's registered grant plus
      // the request-to-grant delay.
      stall_q <= (count_next >= STALL_CNT);
    end
  end

  // Entry storage needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr] <= grant_data;
      mem_src[wr_ptr]  <= grant_idx;
    end
  end

  // Sticky errors; a new event in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf_q   <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      err_ovf_q   <= ovf_evt   | (err_ovf_q   & ~bus.err_clr);
      err_multi_q <= multi_evt | (err_multi_q & ~bus.err_clr);
    end
  end

  // Head outputs are forced to zero when empty so reset leaves all outputs 0.
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_src   = head_valid ? mem_src[rd_ptr]  : '0;
  assign bus.count     = count_q;
  assign bus.stall     = stall_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_multi = err_multi_q;

endmodule
